// File: rtl/pc_gen.sv
// Fetch-stage program counter with stall-aware redirect latching.
// Exception entry / return paths are built only when PC_GEN_EXC_EN is defined.
module pc_gen #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = 32'h0000_3000,
  parameter logic [ADDR_W-1:0]    EXC_VEC  = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target,
  input  logic              exc_req,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              pend_valid,
  output logic              fetch_misaligned
);

  typedef enum logic {RUN, PEND} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pend_target;

  assign pc_plus4         = pc + ADDR_W'(4);
  assign fetch_misaligned = |pc[1:0];
  assign pend_valid       = (state == PEND);

`ifndef PC_GEN_EXC_EN
  logic unused_exc;
  assign unused_exc = ^{exc_req, eret, epc};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= RUN;
      pend_target <= '0;
    end
`ifdef PC_GEN_EXC_EN
    // Exception entry/return override stall and drop any latched redirect.
    else if (exc_req) begin
      pc    <= EXC_VEC;
      state <= RUN;
    end
    else if (eret) begin
      pc    <= epc;
      state <= RUN;
    end
`endif
    else begin
      case (state)
        RUN: begin
          if (stall) begin
            if (redir_valid) begin
              pend_target <= redir_target;
              state       <= PEND;
            end
          end else begin
            pc <= redir_valid ? redir_target : pc_plus4;
          end
        end
        PEND: begin
          if (stall) begin
            if (redir_valid) pend_target <= redir_target;
          end else begin
            // A fresh redirect on the release cycle is newer than the latched one.
            pc    <= redir_valid ? redir_target : pend_target;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed spec scenarios plus random stimulus
// against a queue-based reference model. Honours PC_GEN_EXC_EN like the design.
module tb_pc_gen;

  localparam int unsigned ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset, stall, redir_valid, exc_req, eret;
  logic [31:0] redir_target, epc;
  logic [31:0] pc, pc_plus4;
  logic        pend_valid, fetch_misaligned;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: current pc plus the list of redirects seen while stalled.
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];

  always #5 clk = ~clk;

  pc_gen #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC),
    .EXC_VEC (EXC_VEC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redir_valid     (redir_valid),
    .redir_target    (redir_target),
    .exc_req         (exc_req),
    .eret            (eret),
    .epc             (epc),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .pend_valid      (pend_valid),
    .fetch_misaligned(fetch_misaligned)
  );

  function automatic bit exc_en();
`ifdef PC_GEN_EXC_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_pc = RESET_PC;
      m_pend.delete();
    end else if (exc_en() && exc_req) begin
      m_pc = EXC_VEC;
      m_pend.delete();
    end else if (exc_en() && eret) begin
      m_pc = epc;
      m_pend.delete();
    end else if (stall) begin
      if (redir_valid) m_pend.push_back(redir_target);
    end else begin
      if (redir_valid)            m_pc = redir_target;
      else if (m_pend.size() > 0) m_pc = m_pend[$];
      else                        m_pc = m_pc + 32'd4;
      m_pend.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; redir_valid = 0; redir_target = '0;
    exc_req = 0; eret = 0; epc = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; stall = 1; redir_valid = 1; redir_target = 32'h0000_5550;
    tick(); tick();
    reset = 0; stall = 0; redir_valid = 0;
    n_cmp++; if (pc !== 32'h0000_3000) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0000_3000); end
    n_cmp++; if (pc_plus4 !== 32'h0000_3004) begin n_err++; $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, 32'h0000_3004); end
    n_cmp++; if (pend_valid !== 1'b0) begin n_err++; $display("FAIL reset_pend: got %b want 0", pend_valid); end
    n_cmp++; if (fetch_misaligned !== 1'b0) begin n_err++; $display("FAIL reset_misaligned: got %b want 0", fetch_misaligned); end
  endtask

  task automatic test_sequential();
    logic [31:0] want [3];
    want[0] = 32'h3004; want[1] = 32'h3008; want[2] = 32'h300C;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (pc !== want[i]) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, want[i]); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    tick(); tick();
    n_cmp++; if (pc !== 32'h3008) begin n_err++; $display("FAIL redir_setup: got %h want %h", pc, 32'h3008); end
    redir_valid = 1; redir_target = 32'h3040;
    tick();
    redir_valid = 0;
    n_cmp++; if (pc !== 32'h3040) begin n_err++; $display("FAIL redir_pc: got %h want %h", pc, 32'h3040); end
    n_cmp++; if (pend_valid !== 1'b0) begin n_err++; $display("FAIL redir_pend: got %b want 0", pend_valid); end
    tick();
    n_cmp++; if (pc !== 32'h3044) begin n_err++; $display("FAIL redir_seq: got %h want %h", pc, 32'h3044); end
  endtask

  task automatic test_stall_pend();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    stall = 1; redir_valid = 1; redir_target = 32'h3100;
    tick();
    redir_valid = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (pc !== 32'h3010) begin n_err++; $display("FAIL pend_hold_pc[%0d]: got %h want %h", i, pc, 32'h3010); end
      n_cmp++; if (pend_valid !== 1'b1) begin n_err++; $display("FAIL pend_flag[%0d]: got %b want 1", i, pend_valid); end
      if (i < 2) tick();
    end
    stall = 0;
    tick();
    n_cmp++; if (pc !== 32'h3100) begin n_err++; $display("FAIL pend_release_pc: got %h want %h", pc, 32'h3100); end
    n_cmp++; if (pend_valid !== 1'b0) begin n_err++; $display("FAIL pend_release_flag: got %b want 0", pend_valid); end
    // Latest redirect while stalled wins.
    stall = 1; redir_valid = 1; redir_target = 32'h3100; tick();
    redir_target = 32'h3200; tick();
    redir_valid = 0; tick();
    n_cmp++; if (pc !== 32'h3100) begin n_err++; $display("FAIL latest_hold: got %h want %h", pc, 32'h3100); end
    stall = 0; tick();
    n_cmp++; if (pc !== 32'h3200) begin n_err++; $display("FAIL latest_wins: got %h want %h", pc, 32'h3200); end
  endtask

  task automatic test_exc();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    stall = 1; redir_valid = 1; redir_target = 32'h3100; tick();
    redir_valid = 0;
    exc_req = 1; tick();
    exc_req = 0;
    if (exc_en()) begin
      n_cmp++; if (pc !== 32'h4180) begin n_err++; $display("FAIL exc_pc: got %h want %h", pc, 32'h4180); end
      n_cmp++; if (pend_valid !== 1'b0) begin n_err++; $display("FAIL exc_pend: got %b want 0", pend_valid); end
    end else begin
      n_cmp++; if (pc !== 32'h3010) begin n_err++; $display("FAIL noexc_pc: got %h want %h", pc, 32'h3010); end
      n_cmp++; if (pend_valid !== 1'b1) begin n_err++; $display("FAIL noexc_pend: got %b want 1", pend_valid); end
    end
    eret = 1; epc = 32'h3014; tick();
    eret = 0;
    n_cmp++; if (pc !== (exc_en() ? 32'h3014 : 32'h3010)) begin n_err++; $display("FAIL eret_pc: got %h want %h", pc, exc_en() ? 32'h3014 : 32'h3010); end
    stall = 0; tick();
    n_cmp++; if (pc !== (exc_en() ? 32'h3018 : 32'h3100)) begin n_err++; $display("FAIL post_eret_pc: got %h want %h", pc, exc_en() ? 32'h3018 : 32'h3100); end
  endtask

  task automatic test_wrap_misalign();
    do_reset();
    redir_valid = 1; redir_target = 32'hFFFF_FFFC; tick();
    redir_valid = 0;
    n_cmp++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_plus4: got %h want %h", pc_plus4, 32'h0); end
    tick();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); end
    redir_valid = 1; redir_target = 32'h3002; tick();
    redir_valid = 0;
    n_cmp++; if (pc !== 32'h3002) begin n_err++; $display("FAIL misalign_pc: got %h want %h", pc, 32'h3002); end
    n_cmp++; if (fetch_misaligned !== 1'b1) begin n_err++; $display("FAIL misalign_flag: got %b want 1", fetch_misaligned); end
    // Reset in the middle of a pending redirect discards it.
    stall = 1; redir_valid = 1; redir_target = 32'h3300; tick();
    reset = 1; tick();
    reset = 0; stall = 0; redir_valid = 0;
    n_cmp++; if (pc !== 32'h3000 || pend_valid !== 1'b0) begin n_err++; $display("FAIL reset_in_pend: got pc %h pend %b want pc %h pend 0", pc, pend_valid, 32'h3000); end
    tick();
    n_cmp++; if (pc !== 32'h3004) begin n_err++; $display("FAIL reset_discard: got %h want %h", pc, 32'h3004); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 49) == 0);
      stall        = ($urandom_range(0, 2) == 0);
      redir_valid  = ($urandom_range(0, 3) == 0);
      redir_target = $urandom;
      if ($urandom_range(0, 3) != 0) redir_target[1:0] = 2'b00;
      exc_req      = ($urandom_range(0, 29) == 0);
      eret         = ($urandom_range(0, 29) == 0);
      epc          = $urandom & 32'hFFFF_FFFC;
      tick();
      n_cmp++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || pend_valid !== (m_pend.size() > 0) ||
          fetch_misaligned !== (m_pc[1:0] != 2'b00)) begin
        n_err++;
        $display("FAIL random[%0d]: got pc %h p4 %h pend %b mis %b want pc %h p4 %h pend %b mis %b",
                 i, pc, pc_plus4, pend_valid, fetch_misaligned,
                 m_pc, m_pc + 32'd4, m_pend.size() > 0, m_pc[1:0] != 2'b00);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_pc = '0;
    test_reset();
    test_sequential();
    test_redirect();
    test_stall_pend();
    test_exc();
    test_wrap_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, PC width in bits (>= 8).
REQ-002 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-003 Parameter EXC_VEC, default 32'h0000_4180, exception entry address.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  F-stage hold request from hazard unit.
REQ-007 redir_valid  input  1  D-stage branch/jump taken this cycle.
REQ-008 redir_target  input  ADDR_W  redirect destination.
REQ-009 exc_req  input  1  exception/interrupt entry request.
REQ-010 eret  input  1  exception return request.
REQ-011 epc  input  ADDR_W  return address used by eret.
REQ-012 pc  output  ADDR_W  current fetch address (registered).
REQ-013 pc_plus4  output  ADDR_W  pc + 4, combinational.
REQ-014 pend_valid  output  1  a redirect is latched awaiting stall release.
REQ-015 fetch_misaligned  output  1  pc[1:0] != 0, combinational.

Function
REQ-016 pc_plus4 SHALL equal pc + 4 modulo 2^ADDR_W (all-ones region wraps to 3).
REQ-017 Next-pc priority SHALL be: exc_req > eret > stall > pending/redirect > sequential.
REQ-018 exc_req: pc <= EXC_VEC next edge, pend_valid cleared, stall ignored.
REQ-019 eret (no exc_req): pc <= epc next edge, pend_valid cleared, stall ignored.
REQ-020 State machine SHALL have two states, RUN and PEND; pend_valid is 1 exactly in PEND.
REQ-021 RUN, stall=0, redir_valid=1: pc <= redir_target; stay RUN.
REQ-022 RUN, stall=0, redir_valid=0: pc <= pc_plus4; stay RUN.
REQ-023 RUN, stall=1, redir_valid=1: pc held; pend_target <= redir_target; go PEND.
REQ-024 RUN, stall=1, redir_valid=0: pc held; stay RUN.
REQ-025 PEND, stall=1: pc held; a new redir_valid overwrites pend_target (latest wins); stay PEND.
REQ-026 PEND, stall=0: pc <= redir_target if redir_valid else pend_target; go RUN.
REQ-027 Redirect latency SHALL be one cycle: target visible on pc the cycle after acceptance.
REQ-028 redir_target SHALL be loaded unmodified; misaligned targets are flagged via fetch_misaligned, not corrected.
REQ-029 pc SHALL never change on a cycle with stall=1 unless exc_req or eret is asserted.

Reset
REQ-030 reset=1 at a rising edge SHALL set pc=RESET_PC, state=RUN, pend_valid=0, pend_target=0, overriding all other inputs.
REQ-031 Reset asserted mid-PEND SHALL discard the pending redirect.
REQ-032 First post-reset cycle: pc=RESET_PC, pc_plus4=RESET_PC+4, fetch_misaligned=0 for aligned RESET_PC.

Configuration
REQ-033 Macro PC_GEN_EXC_EN: when defined, exc_req/eret/epc behave per REQ-018/019.
REQ-034 When PC_GEN_EXC_EN is undefined, exc_req, eret, epc SHALL be ignored and pc SHALL never take EXC_VEC or epc; all other behaviour unchanged.

Verification
REQ-035 Reset then 3 free cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C.
REQ-036 At pc=0x3008, redir_valid=1 target 0x3040, stall=0 -> next pc 0x3040, pend_valid=0.
REQ-037 At pc=0x3010, stall=1 with redir_valid=1 target 0x3100 for 1 cycle, stall held 2 more cycles -> pc stays 0x3010, pend_valid=1; stall drops -> pc=0x3100, pend_valid=0.
REQ-038 In PEND (target 0x3100), second redirect 0x3200 while stalled -> after release pc=0x3200.
REQ-039 PC_GEN_EXC_EN defined: exc_req=1 with stall=1 in PEND -> pc=0x4180, pend_valid=0; then eret with epc=0x3014 -> pc=0x3014; macro undefined, same stimulus -> pc held/pend behaviour only.
REQ-040 ADDR_W=32, redirect to 0xFFFF_FFFC -> next sequential pc 0x0000_0000; redirect to 0x3002 -> fetch_misaligned=1; reset asserted during PEND -> pc=0x3000, pend_valid=0.
